// File: rtl/alu_regfile_2r1w_pkg.sv
// alu_regfile_2r1w_pkg: shared types for the two-read one-write register file
package alu_regfile_2r1w_pkg;
  typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/alu_regfile_2r1w_if.sv
// alu_regfile_2r1w_if: write, dual read and clear signals of the register file
interface alu_regfile_2r1w_if #(parameter int DATA_W = 32, parameter int ADDR_W = 4);
  logic              we;
  logic [ADDR_W-1:0] wAddr;
  logic [DATA_W-1:0] wData;
  logic              reA;
  logic              reB;
  logic [ADDR_W-1:0] rAddrA;
  logic [ADDR_W-1:0] rAddrB;
  logic [DATA_W-1:0] rDataA;
  logic [DATA_W-1:0] rDataB;
  logic              rValidA;
  logic              rValidB;
  logic              clr;
  logic              busy;
  modport master (output we, wAddr, wData, reA, reB, rAddrA, rAddrB, clr,
                  input rDataA, rDataB, rValidA, rValidB, busy);
  modport slave (input we, wAddr, wData, reA, reB, rAddrA, rAddrB, clr,
                 output rDataA, rDataB, rValidA, rValidB, busy);
endinterface

// File: rtl/alu_regfile_2r1w_rdport.sv
// alu_regfile_rdport: registered read mux with write-first bypass and valid flag
module alu_regfile_rdport #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem [DEPTH],
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= en;
      if (en) rdata <= wen && waddr == addr ? wdata : mem[addr];
    end
endmodule

// File: rtl/alu_regfile_2r1w.sv
// alu_regfile_2r1w: 2-read 1-write register file with a sequential clear sweep
module alu_regfile_2r1w
  import alu_regfile_2r1w_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic reset_n,
  alu_regfile_2r1w_if.slave bus
);
  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic              busy, last, wen, ena, enb;
  always_comb begin
    busy    = state == CLEAR;
    last    = cnt == ADDR_W'(DEPTH - 1);
    wen     = bus.we && !busy;
    ena     = bus.reA && !busy;
    enb     = bus.reB && !busy;
    state_n = busy ? (last ? IDLE : CLEAR) : (bus.clr ? CLEAR : IDLE);
    cnt_n   = busy && !last ? cnt + 1'b1 : '0;
  end
  assign bus.busy = busy;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  // A write accepted on the clr edge lands now; the sweep overwrites it later
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (busy) begin
      mem[cnt] <= '0;
    end else if (wen) begin
      mem[bus.wAddr] <= bus.wData;
    end
  alu_regfile_rdport #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rda (
    .clk(clk), .reset_n(reset_n), .en(ena), .addr(bus.rAddrA), .wen(wen),
    .waddr(bus.wAddr), .wdata(bus.wData), .mem(mem), .rdata(bus.rDataA), .rvalid(bus.rValidA)
  );
  alu_regfile_rdport #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rdb (
    .clk(clk), .reset_n(reset_n), .en(enb), .addr(bus.rAddrB), .wen(wen),
    .waddr(bus.wAddr), .wdata(bus.wData), .mem(mem), .rdata(bus.rDataB), .rvalid(bus.rValidB)
  );
endmodule

// File: tb/tb_alu_regfile_2r1w.sv
// tb_alu_regfile_2r1w: directed and random checks of the register file against a reference model
module tb_alu_regfile_2r1w;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;
  alu_regfile_2r1w_if #(.DATA_W(32), .ADDR_W(4)) b ();
  alu_regfile_2r1w #(.DATA_W(32), .DEPTH(16)) dut (.clk(clk), .reset_n(reset_n), .bus(b));
  alu_regfile_2r1w_if #(.DATA_W(8), .ADDR_W(2)) s ();
  alu_regfile_2r1w #(.DATA_W(8), .DEPTH(4)) dut_s (.clk(clk), .reset_n(reset_n), .bus(s));
  logic [31:0] m [16];
  int          left, idx, compared, mismatched, n;
  logic [31:0] ea, eb;
  logic        eva, evb;
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask
  task automatic chk_all(input string t);
    chk({t, ".rDataA"}, b.rDataA, ea);
    chk({t, ".rDataB"}, b.rDataB, eb);
    chk({t, ".rValidA"}, 32'(b.rValidA), 32'(eva));
    chk({t, ".rValidB"}, 32'(b.rValidB), 32'(evb));
    chk({t, ".busy"}, 32'(b.busy), 32'(left != 0));
  endtask
  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = '0;
    left = 0; idx = 0; ea = '0; eb = '0; eva = 1'b0; evb = 1'b0;
  endtask
  task automatic cyc(input string t, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                     input logic ra, input logic [3:0] aa, input logic rb, input logic [3:0] ab,
                     input logic c);
    b.we = we; b.wAddr = wa; b.wData = wd; b.reA = ra; b.rAddrA = aa;
    b.reB = rb; b.rAddrB = ab; b.clr = c;
    @(posedge clk);
    if (left == 0) begin
      eva = ra; evb = rb;
      if (ra) ea = we && wa == aa ? wd : m[aa];
      if (rb) eb = we && wa == ab ? wd : m[ab];
      if (we) m[wa] = wd;
      if (c) begin left = 16; idx = 0; end
    end else begin
      eva = 1'b0; evb = 1'b0;
      m[idx] = '0; idx++; left--;
    end
    #1;
    chk_all(t);
  endtask
  initial begin
    compared = 0; mismatched = 0;
    b.we = 0; b.wAddr = 0; b.wData = 0; b.reA = 0; b.reB = 0; b.rAddrA = 0; b.rAddrB = 0; b.clr = 0;
    s.we = 0; s.wAddr = 0; s.wData = 0; s.reA = 0; s.reB = 0; s.rAddrA = 0; s.rAddrB = 0; s.clr = 0;
    reset_n = 1'b0;
    model_reset();
    #12;
    chk_all("reset");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    cyc("wr3", 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    cyc("rd3", 0, 0, 0, 1, 3, 0, 0, 0);
    chk("rd3.exact", b.rDataA, 32'hDEADBEEF);
    cyc("rd3.after", 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("wf5", 1, 5, 32'h12345678, 1, 5, 1, 5, 0);
    chk("wf5.A", b.rDataA, 32'h12345678);
    chk("wf5.B", b.rDataB, 32'h12345678);
    for (int i = 0; i < 16; i++) cyc("fill", 1, 4'(i), 32'h100 + 32'(i), 0, 0, 0, 0, 0);
    cyc("clr", 0, 0, 0, 0, 0, 0, 0, 1);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      cyc("sweep", i == 3, 15, 32'hFFFFFFFF, 1, 4'(i), 1, 4'(15 - i), i == 5);
      if (b.busy) n++;
    end
    chk("sweep.len", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) cyc("cleared", 0, 0, 0, 1, 4'(i), 1, 4'(15 - i), 0);
    chk("addr15.zero", b.rDataA, 32'h0);
    for (int i = 0; i < 400; i++)
      cyc("rand", 1'($urandom), 4'($urandom), $urandom, 1'($urandom), 4'($urandom),
          1'($urandom), 4'($urandom), $urandom_range(0, 39) == 0);
    for (int i = 0; i < 16; i++) cyc("fill2", 1, 4'(i), $urandom, 1, 4'(i), 0, 0, 0);
    cyc("clr2", 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) cyc("sweep2", 0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk_all("abort");
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cyc("post", 0, 0, 0, 1, 4'(i), 0, 0, 0);
    cyc("wr9", 1, 9, 32'hCAFEF00D, 0, 0, 0, 0, 0);
    cyc("rd9", 0, 0, 0, 1, 9, 1, 9, 0);
    chk("rd9.exact", b.rDataB, 32'hCAFEF00D);
    s.clr = 1'b1;
    @(posedge clk); #1;
    s.clr = 1'b0;
    n = 0;
    while (s.busy && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk("small.sweep", 32'(n), 32'd4);
    s.we = 1'b1; s.wAddr = 2'd3; s.wData = 8'hA5;
    @(posedge clk); #1;
    s.we = 1'b0; s.reA = 1'b1; s.rAddrA = 2'd3;
    @(posedge clk); #1;
    s.reA = 1'b0;
    chk("small.rd3", 32'(s.rDataA), 32'hA5);
    chk("small.valid", 32'(s.rValidA), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/alu_regfile_2r1w.md
ALU_REGFILE_2R1W -- requirements
Module: alu_regfile_2r1w

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the entry width in bits.
REQ-002 Parameter DEPTH, default 16, SHALL set the entry count; legal values are powers of two from 2 to 256.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), SHALL be derived and never overridden.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-006 Port we, input, 1 bit, SHALL be the write enable.
REQ-007 Port wAddr, input, ADDR_W bits, SHALL be the write address.
REQ-008 Port wData, input, DATA_W bits, SHALL be the write data.
REQ-009 Port reA / reB, input, 1 bit each, SHALL be the read enables for ports A and B.
REQ-010 Port rAddrA / rAddrB, input, ADDR_W bits each, SHALL be the read addresses.
REQ-011 Port rDataA / rDataB, output, DATA_W bits each, SHALL be the registered read data.
REQ-012 Port rValidA / rValidB, output, 1 bit each, SHALL pulse high for one cycle when the matching rData is updated.
REQ-013 Port clr, input, 1 bit, SHALL request a sequential clear of all entries.
REQ-014 Port busy, output, 1 bit, SHALL be high while a clear sweep is in progress.

Function
REQ-015 Write: on the edge with we=1 and busy=0, entry[wAddr] SHALL take wData.
REQ-016 Read: on the edge with reX=1 and busy=0, rDataX SHALL take entry[rAddrX] and rValidX SHALL be 1 in the following cycle. Latency is 1 cycle.
REQ-017 With reX=0 or busy=1, rValidX SHALL be 0 and rDataX SHALL hold its value.
REQ-018 Write and both reads SHALL operate in the same cycle, independently of each other.
REQ-019 Read-during-write to the same address (write-first) SHALL return the new wData on that port.
REQ-020 Both ports reading the same address SHALL each return the same data.
REQ-021 The state machine SHALL have two states, IDLE and CLEAR; reset SHALL enter IDLE.
REQ-022 In IDLE, clr=1 SHALL move the FSM to CLEAR, load the sweep counter with 0, and set busy=1 from the next cycle.
REQ-023 clr SHALL have priority over a same-cycle we/re: the write and reads SHALL still be performed that cycle, and the sweep SHALL then overwrite the entry.
REQ-024 In CLEAR, each cycle SHALL zero entry[counter] and increment the counter.
REQ-025 When the counter equals DEPTH-1, the FSM SHALL zero that entry and return to IDLE, with busy=0 in the next cycle; the sweep lasts exactly DEPTH cycles.
REQ-026 In CLEAR, we, reA, reB and clr SHALL be ignored; inputs are not queued.
REQ-027 The counter SHALL be ADDR_W bits wide and SHALL NOT wrap past DEPTH-1 within one sweep.

Reset
REQ-028 While reset_n=0, all entries, rDataA, rDataB and the counter SHALL be 0, rValidA, rValidB and busy SHALL be 0, and the FSM SHALL be IDLE.
REQ-029 Asserting reset_n mid-sweep SHALL abort the sweep immediately; the first edge after release SHALL be IDLE behaviour.

Structure
REQ-030 The FSM state encoding (IDLE, CLEAR) SHALL live in the shared ALU package.
REQ-031 The block SHALL contain one sub-module, alu_regfile_rdport, instanced twice; each instance holds the registered read mux, the write-first bypass and the valid flag for one port.
REQ-032 The storage SHALL be a single DEPTH x DATA_W register array in the top level.

Verification
REQ-033 Write 0xDEADBEEF to addr 3, then reA with rAddrA=3 -> next cycle rDataA=0xDEADBEEF, rValidA=1; the cycle after, rValidA=0.
REQ-034 Same cycle: we to addr 5 with 0x12345678, reA addr 5, reB addr 5 -> next cycle rDataA=rDataB=0x12345678.
REQ-035 Fill all 16 entries with 0x100+i, pulse clr -> busy high for exactly 16 cycles; reads issued during the sweep give rValid=0; afterwards every entry reads 0.
REQ-036 During a sweep, we to addr 15 with 0xFFFFFFFF -> after the sweep, addr 15 reads 0.
REQ-037 Assert reset_n=0 at sweep cycle 7 -> busy=0 and the rData ports are 0 immediately; after release, writing and reading addr 9 works with no residual sweep.
REQ-038 Instance with DATA_W=8, DEPTH=4 -> the clr sweep lasts 4 cycles; wAddr=3 write then read returns the correct value.
